// File: rtl/vlsu_bank_scheduler_pkg.sv
// Shared constants and types for the vector-store bank scheduler.
// Banks are word-interleaved four ways on addr[1:0].
package vlsu_bank_scheduler_pkg;

    localparam int unsigned NumBanks = 4;
    localparam int unsigned NumLanes = 4;

    localparam logic [1:0] Bank0 = 2'd0;
    localparam logic [1:0] Bank1 = 2'd1;
    localparam logic [1:0] Bank2 = 2'd2;
    localparam logic [1:0] Bank3 = 2'd3;

    // Vector lanes always store a full word.
    localparam logic [3:0] VWriteBe = 4'b1111;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    // Isolate the lowest set bit; this gives fixed priority to the lowest lane index.
    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/vlsu_bank_scheduler_bank_pick.sv
// Picks the lowest-index pending lane that targets one bank.
// Output is a one-hot lane select plus a valid flag.
module vlsu_bank_scheduler_bank_pick
    import vlsu_bank_scheduler_pkg::*;
#(
    parameter logic [1:0] Bank = Bank0
) (
    input  logic [3:0] pending,
    input  logic [7:0] lane_bank,
    output logic [3:0] grant_oh,
    output logic       valid
);

    logic [3:0] hit;

    always_comb begin
        hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hit[i] = pending[i] && (lane_bank[2*i +: 2] == Bank);
        end
        grant_oh = lowest_one(hit);
        valid    = |hit;
    end

endmodule

// File: rtl/vlsu_bank_scheduler.sv
// Schedules a 4-lane vector store batch onto four interleaved data-memory banks,
// serialising same-bank lanes and letting scalar stores pre-empt their bank.
module vlsu_bank_scheduler
    import vlsu_bank_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned NLANES = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              v_valid,
    output logic              v_ready,
    input  logic [3:0]        v_mask,
    input  logic [ADDR_W-1:0] v_addr0,
    input  logic [ADDR_W-1:0] v_addr1,
    input  logic [ADDR_W-1:0] v_addr2,
    input  logic [ADDR_W-1:0] v_addr3,
    input  logic [31:0]       v_data0,
    input  logic [31:0]       v_data1,
    input  logic [31:0]       v_data2,
    input  logic [31:0]       v_data3,
    input  logic              v_flush,
    output logic              v_done,
    input  logic [3:0]        s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_data,
    output logic [3:0]        dm_write_0,
    output logic [3:0]        dm_write_1,
    output logic [3:0]        dm_write_2,
    output logic [3:0]        dm_write_3,
    output logic [ADDR_W-3:0] dm_addr_0,
    output logic [ADDR_W-3:0] dm_addr_1,
    output logic [ADDR_W-3:0] dm_addr_2,
    output logic [ADDR_W-3:0] dm_addr_3,
    output logic [31:0]       dm_data_0,
    output logic [31:0]       dm_data_1,
    output logic [31:0]       dm_data_2,
    output logic [31:0]       dm_data_3
);

    state_e            state_q;
    logic [3:0]        pending_q;
    logic [3:0]        pending_d;
    logic              v_done_q;
    logic              v_ready_q;
    logic [ADDR_W-1:0] lane_addr_q [NLANES];
    logic [31:0]       lane_data_q [NLANES];

    logic [7:0]        lane_bank;
    logic [3:0]        cand_oh    [NumBanks];
    logic [3:0]        cand_valid;
    logic [3:0]        bank_granted;
    logic [3:0]        grant;
    logic              s_hit;
    logic [1:0]        s_bank;

    logic [3:0]        bank_we    [NumBanks];
    logic [ADDR_W-3:0] bank_addr  [NumBanks];
    logic [31:0]       bank_data  [NumBanks];

    always_comb begin
        lane_bank = 8'h00;
        for (int i = 0; i < 4; i++) begin
            lane_bank[2*i +: 2] = lane_addr_q[i][1:0];
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_pick
        vlsu_bank_scheduler_bank_pick #(
            .Bank (2'(b))
        ) u_pick (
            .pending   (pending_q),
            .lane_bank (lane_bank),
            .grant_oh  (cand_oh[b]),
            .valid     (cand_valid[b])
        );
    end

    // Grant arbitration: a scalar store on a bank blocks that bank's vector candidate.
    always_comb begin
        s_hit        = (s_we != 4'b0000);
        s_bank       = s_addr[1:0];
        bank_granted = 4'b0000;
        grant        = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            bank_granted[b] = (state_q == StBusy) && !v_flush && cand_valid[b] &&
                              !(s_hit && (s_bank == 2'(b)));
            if (bank_granted[b]) begin
                grant = grant | cand_oh[b];
            end
        end
        pending_d = v_flush ? 4'b0000 : (pending_q & ~grant);
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank_we[b]   = 4'b0000;
            bank_addr[b] = '0;
            bank_data[b] = 32'h0;
            if (s_hit && (s_bank == 2'(b))) begin
                bank_we[b]   = s_we;
                bank_addr[b] = s_addr[ADDR_W-1:2];
                bank_data[b] = s_data;
            end else if (bank_granted[b]) begin
                bank_we[b] = VWriteBe;
                for (int i = 0; i < 4; i++) begin
                    if (cand_oh[b][i]) begin
                        bank_addr[b] = lane_addr_q[i][ADDR_W-1:2];
                        bank_data[b] = lane_data_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= StIdle;
            pending_q <= 4'b0000;
            v_done_q  <= 1'b0;
            v_ready_q <= 1'b1;
        end else begin
            v_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (v_valid) begin
                        pending_q <= v_mask;
                        state_q   <= StBusy;
                        v_ready_q <= 1'b0;
                    end
                end
                StBusy: begin
                    pending_q <= pending_d;
                    if (pending_d == 4'b0000) begin
                        state_q   <= StIdle;
                        v_done_q  <= 1'b1;
                        v_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Lane payload is only meaningful while pending; held until the next accept.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && v_valid) begin
            lane_addr_q[0] <= v_addr0;
            lane_addr_q[1] <= v_addr1;
            lane_addr_q[2] <= v_addr2;
            lane_addr_q[3] <= v_addr3;
            lane_data_q[0] <= v_data0;
            lane_data_q[1] <= v_data1;
            lane_data_q[2] <= v_data2;
            lane_data_q[3] <= v_data3;
        end
    end

    assign v_ready    = v_ready_q;
    assign v_done     = v_done_q;
    assign dm_write_0 = bank_we[0];
    assign dm_write_1 = bank_we[1];
    assign dm_write_2 = bank_we[2];
    assign dm_write_3 = bank_we[3];
    assign dm_addr_0  = bank_addr[0];
    assign dm_addr_1  = bank_addr[1];
    assign dm_addr_2  = bank_addr[2];
    assign dm_addr_3  = bank_addr[3];
    assign dm_data_0  = bank_data[0];
    assign dm_data_1  = bank_data[1];
    assign dm_data_2  = bank_data[2];
    assign dm_data_3  = bank_data[3];

endmodule
